// File: rtl/conv_encoder_tx.sv
// Frame-buffered rate-1/2 K=3 convolutional encoder (G0=111, G1=101).
// Emits one symbol per buffered bit plus zero flush bits ending in state 0.
module conv_encoder_tx #(
  parameter int MAX_FRAME = 32,
  parameter int TAIL_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       sym_valid,
  output logic [1:0] sym_out,
  input  logic       sym_ready,
  output logic       frame_done,
  output logic       busy,
  output logic       overflow
);

  localparam int MAX_DATA = MAX_FRAME - TAIL_BITS;
  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam int BW = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_TAIL,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           enc_q, enc_d;
  logic [MAX_DATA-1:0]  dbuf_q, dbuf_d;
  logic [CW-1:0]        len_q, len_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic                 cur_bit;

  function automatic logic [1:0] enc_sym(
    input logic [1:0] s,
    input logic       b
  );
    return {s[1] ^ s[0] ^ b, s[1] ^ b};
  endfunction

  always_comb begin
    state_d    = state_q;
    enc_d      = enc_q;
    dbuf_d     = dbuf_q;
    len_d      = len_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    cur_bit    = 1'b0;
    in_ready   = 1'b0;
    sym_valid  = 1'b0;
    sym_out    = 2'b00;
    frame_done = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dbuf_d[0] = in_bit;
          len_d     = CW'(1);
          ovf_d     = 1'b0;
          if (in_last || MAX_DATA == 1) begin
            state_d = S_SEND;
            enc_d   = 2'b00;
            idx_d   = '0;
            ovf_d   = ~in_last;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dbuf_d[len_q[BW-1:0]] = in_bit;
          len_d = len_q + CW'(1);
          // a full buffer without in_last means the frame was truncated
          if (in_last || len_q == CW'(MAX_DATA - 1)) begin
            state_d = S_SEND;
            enc_d   = 2'b00;
            idx_d   = '0;
            ovf_d   = ~in_last;
          end
        end
      end

      S_SEND: begin
        busy      = 1'b1;
        sym_valid = 1'b1;
        cur_bit   = dbuf_q[idx_q[BW-1:0]];
        sym_out   = enc_sym(enc_q, cur_bit);
        if (sym_ready) begin
          enc_d = {enc_q[0], cur_bit};
          idx_d = idx_q + CW'(1);
          if (idx_q == len_q - CW'(1)) begin
            state_d = (TAIL_BITS > 0) ? S_TAIL : S_DONE;
          end
        end
      end

      S_TAIL: begin
        busy      = 1'b1;
        sym_valid = 1'b1;
        sym_out   = enc_sym(enc_q, 1'b0);
        if (sym_ready) begin
          enc_d = {enc_q[0], 1'b0};
          idx_d = idx_q + CW'(1);
          // idx keeps counting past len so the tail needs no extra counter
          if (idx_q == len_q + CW'(TAIL_BITS - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        frame_done = 1'b1;
        idx_d      = '0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      enc_q   <= 2'b00;
      dbuf_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      dbuf_q  <= dbuf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Scoreboard bench for conv_encoder_tx: a polynomial reference model
// fills queues, a negedge monitor pops and compares emitted symbols.
module tb_conv_encoder_tx;

  localparam int MAX_FRAME = 32;
  localparam int TAIL_BITS = 2;
  localparam int MAX_DATA  = MAX_FRAME - TAIL_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       in_last;
  logic       in_ready;
  logic       sym_valid;
  logic [1:0] sym_out;
  logic       sym_ready;
  logic       frame_done;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  int         flen_q[$];
  int         rx_cnt = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         fl_n;
  bit         stalled = 1'b0;
  bit         held = 1'b0;
  logic [1:0] held_sym;
  bit         manual = 1'b1;
  bit         rnd = 1'b0;

  always #5 clk = ~clk;

  conv_encoder_tx #(
    .MAX_FRAME(MAX_FRAME),
    .TAIL_BITS(TAIL_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sym_valid (sym_valid),
    .sym_out   (sym_out),
    .sym_ready (sym_ready),
    .frame_done(frame_done),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compares every accepted symbol and every frame_done pulse.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && sym_valid) chk("hold_stable", sym_out, held_sym);
      held     = sym_valid && !sym_ready;
      held_sym = sym_out;
      if (sym_valid && !sym_ready) stalled = 1'b1;
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_symbol", 1, 0);
        end else begin
          if (rx_cnt == 0) first_cyc = cyc;
          chk("sym", sym_out, exp_q.pop_front());
          rx_cnt++;
        end
      end
      if (frame_done) begin
        if (flen_q.size() == 0) begin
          flag("unexpected_frame_done", 1, 0);
        end else begin
          fl_n = flen_q.pop_front();
          chk("frame_sym_count", rx_cnt, fl_n);
          if (!stalled) chk("frame_done_latency", cyc - first_cyc, fl_n);
        end
        rx_cnt  = 0;
        stalled = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!manual) sym_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Reference: y0[k] = u[k]^u[k-1]^u[k-2], y1[k] = u[k]^u[k-2], zero-padded.
  task automatic model_frame(input int len, input logic [63:0] d);
    logic [63:0] u;
    logic a, b, c;
    u = '0;
    for (int i = 0; i < len; i++) u[i] = d[i];
    for (int k = 0; k < len + TAIL_BITS; k++) begin
      a = u[k];
      b = (k >= 1) ? u[k-1] : 1'b0;
      c = (k >= 2) ? u[k-2] : 1'b0;
      exp_q.push_back({a ^ b ^ c, a ^ c});
    end
    flen_q.push_back(len + TAIL_BITS);
  endtask

  task automatic drive_bit(input logic b, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (!in_ready) flag("in_ready_timeout", t, 300);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [63:0] d,
                            input bit has_last, input bit gaps);
    int  len;
    bit  exp_ovf;
    len     = (n > MAX_DATA) ? MAX_DATA : n;
    exp_ovf = (len == MAX_DATA) && !(has_last && n == MAX_DATA);
    model_frame(len, d);
    for (int i = 0; i < len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      if (gaps) #1;
      drive_bit(d[i], has_last && (i == n - 1));
    end
    if (n > MAX_DATA) begin
      in_valid = 1'b1;
      in_bit   = d[MAX_DATA];
    end
    @(negedge clk);
    chk("first_sym_latency", sym_valid, 1'b1);
    chk("busy_in_send", busy, 1'b1);
    chk("overflow_flag", overflow, exp_ovf);
    if (n > MAX_DATA) chk("ovf_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (flen_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (flen_q.size() != 0) flag("frame_timeout", flen_q.size(), 0);
    chk("exp_queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    sym_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sym_valid", sym_valid, 1'b0);
    chk("rst_sym_out", sym_out, 2'b00);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;

    // 1,0,1,1 -> 11,10,00,01,01,11
    send_frame(4, 64'b1101, 1'b1, 1'b0);
    wait_done();

    // single 0 bit frame
    send_frame(1, 64'b0, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // 1,1,0 with the second symbol stalled three cycles
    send_frame(3, 64'b011, 1'b1, 1'b0);
    sym_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_sym", sym_out, 2'b01);
      chk("stall_valid", sym_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    sym_ready = 1'b1;
    wait_done();

    // 31 ones, no in_last: truncated at MAX_DATA
    send_frame(31, 64'h7FFF_FFFF, 1'b0, 1'b0);
    wait_done();
    chk("overflow_sticky", overflow, 1'b1);
    send_frame(1, 64'b1, 1'b1, 1'b0);
    wait_done();

    // reset during SEND at idx 2
    manual = 1'b0;
    rnd    = 1'b0;
    send_frame(6, 64'b101101, 1'b1, 1'b0);
    t = 0;
    while (rx_cnt < 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (rx_cnt < 2) flag("rst_test_timeout", rx_cnt, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    flen_q.delete();
    rx_cnt  = 0;
    stalled = 1'b0;
    @(negedge clk);
    chk("mid_rst_sym_valid", sym_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_overflow", overflow, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    send_frame(4, 64'b1101, 1'b1, 1'b0);
    wait_done();

    // random frames with random backpressure and input gaps
    rnd = 1'b1;
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, MAX_DATA + 1);
      send_frame(n, {$urandom(), $urandom()}, (n <= MAX_DATA),
                 1'b1);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
